rx_deflusher: RTL and testbench
===============================

// Module: rx_deflusher
// PURPOSE
//  Receive-side counterpart of the TX flusher: sits between RX lane deswizzle and the upper RX
//  data path, one 192-bit word per valid. Strips flusher-inserted `ESC_PACK/`FLUSH_PACK pairs,
//  un-escapes data words equal to `ESC_PACK, and flags malformed escapes. Also provides a
//  link-alive indication from the TX idle-flush guarantee.
// PARAMETERS
//  DW           192  data word width (must equal width of `ESC_PACK/`FLUSH_PACK)
//  ESC_TIMEOUT  16   enabled cycles allowed between ESC and its following word
//  ALIVE_LIMIT  32   enabled cycles with no valid word before link_alive drops
//  CNT_W        16   width of flush/error statistics counters
// PORTS
//  clk              in   1      clock
//  reset_n          in   1      asynchronous, active-low reset
//  in_enable        in   1      clock enable; all state advances only when 1
//  in_rxdata        in   DW     received word
//  in_rxdata_valid  in   1      in_rxdata valid this cycle
//  in_clr_err       in   1      clears out_err_sticky and out_err_cnt
//  out_rxdata       out  DW     payload word to upper layer
//  out_rxdata_valid out  1      out_rxdata valid
//  out_flush_seen   out  1      1-cycle pulse: ESC+FLUSH pair consumed
//  out_esc_err      out  1      1-cycle pulse: malformed or timed-out escape
//  out_err_sticky   out  1      set by any esc error, held until in_clr_err
//  out_flush_cnt    out  CNT_W  saturating count of flush pairs
//  out_err_cnt      out  CNT_W  saturating count of esc errors
//  out_link_alive   out  1      1 while valid words arrive within ALIVE_LIMIT cycles
// BEHAVIOUR
//  - All outputs registered. Reset: out_rxdata=0, all valid/pulses=0, sticky=0, counters=0,
//    out_link_alive=0, state=NORMAL, esc_timer=0, silence_cnt=ALIVE_LIMIT.
//  - in_enable=0: inputs ignored; state, timers, counters hold; out_rxdata_valid and pulses
//    register 0; out_rxdata holds.
//  - Latency: payload word appears on out_rxdata exactly 1 enabled cycle after acceptance.
//  - State NORMAL:
//    valid & word!=`ESC_PACK -> forward word.
//    valid & word==`ESC_PACK -> no output, go GOT_ESC, esc_timer=0.
//  - State GOT_ESC (escape pending):
//    valid & `ESC_PACK   -> forward one `ESC_PACK as payload, go NORMAL.
//    valid & `FLUSH_PACK -> no output, pulse out_flush_seen, flush_cnt+1, go NORMAL.
//    valid & other word  -> pulse out_esc_err, err_cnt+1, sticky=1, forward the word
//                           (pending ESC discarded), go NORMAL.
//    no valid            -> esc_timer+1; at esc_timer==ESC_TIMEOUT-1 pulse out_esc_err,
//                           err_cnt+1, sticky=1, ESC discarded, go NORMAL.
//  - Gaps between ESC and its partner word are legal (TX waits on lane idle) up to timeout.
//  - Counters saturate at all-ones, never wrap.
//  - in_clr_err: clears sticky and err_cnt; simultaneous error in same cycle wins
//    (sticky=1, err_cnt=1). Flush counter is not cleared by in_clr_err.
//  - Liveness: silence_cnt=0 on any accepted valid word (incl. ESC/FLUSH), else +1
//    saturating at ALIVE_LIMIT; out_link_alive = (silence_cnt < ALIVE_LIMIT), registered.
//  - reset_n asserted mid-escape: pending ESC discarded, no error reported.
//  - Assertion (sim): out_flush_seen and out_rxdata_valid never both 1 in same cycle.
// TESTING
//  1 Words A,B,C back-to-back valid -> A,B,C on out_rxdata, 1 cycle later, no pulses.
//  2 ESC,(3 idle cycles),FLUSH -> no output word, one out_flush_seen, out_flush_cnt=1.
//  3 ESC,ESC,D -> out_rxdata=`ESC_PACK then D; no err, flush_cnt unchanged.
//  4 ESC then word E -> E forwarded, out_esc_err pulse, sticky=1, err_cnt=1; in_clr_err -> 0.
//  5 ESC then 16 idle cycles -> out_esc_err on 16th, state NORMAL; next word F forwarded.
//  6 After reset, first valid word -> link_alive=1 next cycle; 32 silent cycles -> link_alive=0;
//    toggle in_enable=0 mid-stream -> counters/state frozen, resume without loss.

Source files
------------

// File: rtl/rx_deflusher_if.sv
// rx_deflusher_if: groups the RX data path signals of rx_deflusher.
//   master : drives in_* (upstream RX lane logic / testbench)
//   slave  : the deflusher, consumes in_* and drives out_*
// Signals:
//   in_enable        clock enable
//   in_rxdata        received word (DW bits)
//   in_rxdata_valid  in_rxdata valid this cycle
//   in_clr_err       clear sticky error flag and error counter
//   out_rxdata       payload word to upper layer
//   out_rxdata_valid out_rxdata valid
//   out_flush_seen   pulse: ESC+FLUSH pair consumed
//   out_esc_err      pulse: malformed or timed-out escape
//   out_err_sticky   held escape-error flag
//   out_flush_cnt    saturating flush-pair count
//   out_err_cnt      saturating escape-error count
//   out_link_alive   valid words are still arriving
// Also provides the shared escape/flush code words, unless they are defined elsewhere.
`ifndef ESC_PACK
`define ESC_PACK 192'hE5E5E5E5_E5E5E5E5_E5E5E5E5_E5E5E5E5_E5E5E5E5_E5E5E5E5
`endif
`ifndef FLUSH_PACK
`define FLUSH_PACK 192'hF1F1F1F1_F1F1F1F1_F1F1F1F1_F1F1F1F1_F1F1F1F1_F1F1F1F1
`endif

interface rx_deflusher_if #(
  parameter int DW    = 192,
  parameter int CNT_W = 16
);
  logic             in_enable;
  logic [DW-1:0]    in_rxdata;
  logic             in_rxdata_valid;
  logic             in_clr_err;
  logic [DW-1:0]    out_rxdata;
  logic             out_rxdata_valid;
  logic             out_flush_seen;
  logic             out_esc_err;
  logic             out_err_sticky;
  logic [CNT_W-1:0] out_flush_cnt;
  logic [CNT_W-1:0] out_err_cnt;
  logic             out_link_alive;

  modport master (
    output in_enable, in_rxdata, in_rxdata_valid, in_clr_err,
    input  out_rxdata, out_rxdata_valid, out_flush_seen, out_esc_err,
           out_err_sticky, out_flush_cnt, out_err_cnt, out_link_alive
  );

  modport slave (
    input  in_enable, in_rxdata, in_rxdata_valid, in_clr_err,
    output out_rxdata, out_rxdata_valid, out_flush_seen, out_esc_err,
           out_err_sticky, out_flush_cnt, out_err_cnt, out_link_alive
  );
endinterface

// File: rtl/rx_deflusher.sv
// rx_deflusher: receive-side counterpart of the TX flusher. Removes ESC+FLUSH
// pairs inserted by the transmitter, turns ESC+ESC back into one ESC payload
// word, reports malformed or timed-out escapes, and derives a link-alive flag
// from the transmitter's idle-flush guarantee.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   rx_if    rx_deflusher_if.slave (all data, control and status signals)
// All outputs are registered; every state element advances only when
// in_enable is 1.

// Sim-only checker: a consumed flush pair never produces a payload word.
module rx_deflusher_chk (
  input logic clk,
  input logic reset_n,
  input logic flush_seen,
  input logic rxdata_valid
);
  a_flush_excl_valid: assert property (@(posedge clk) disable iff (!reset_n)
    !(flush_seen && rxdata_valid));
endmodule

module rx_deflusher #(
  parameter int DW          = 192,
  parameter int ESC_TIMEOUT = 16,
  parameter int ALIVE_LIMIT = 32,
  parameter int CNT_W       = 16
) (
  input logic           clk,
  input logic           reset_n,
  rx_deflusher_if.slave rx_if
);
  localparam int TW = $clog2(ESC_TIMEOUT + 1);
  localparam int SW = $clog2(ALIVE_LIMIT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ESC_TIMEOUT - 1);
  localparam logic [SW-1:0] SIL_LIMIT = SW'(ALIVE_LIMIT);

  typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_GOT_ESC = 1'b1} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [SW-1:0]    silence_q, silence_d;
  logic [DW-1:0]    data_q, data_d;
  logic             valid_q, valid_d;
  logic             flush_q, flush_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             alive_q, alive_d;

  logic en_s, vld_s, is_esc_s, is_flush_s;
  assign en_s       = rx_if.in_enable;
  assign vld_s      = rx_if.in_enable & rx_if.in_rxdata_valid;
  assign is_esc_s   = (rx_if.in_rxdata == DW'(`ESC_PACK));
  assign is_flush_s = (rx_if.in_rxdata == DW'(`FLUSH_PACK));

  // Escape FSM next state, payload forwarding, pulses, counters and liveness.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    silence_d   = silence_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    flush_d     = 1'b0;
    err_d       = 1'b0;
    sticky_d    = sticky_q;
    flush_cnt_d = flush_cnt_q;
    err_cnt_d   = err_cnt_q;
    alive_d     = alive_q;

    if (vld_s) begin
      case (state_q)
        ST_NORMAL: begin
          if (is_esc_s) begin
            state_d = ST_GOT_ESC;
            timer_d = '0;
          end else begin
            valid_d = 1'b1;
          end
        end
        ST_GOT_ESC: begin
          // Any word resolves the pending escape.
          state_d = ST_NORMAL;
          timer_d = '0;
          if (is_esc_s) begin
            valid_d = 1'b1;
          end else if (is_flush_s) begin
            flush_d = 1'b1;
          end else begin
            // Malformed escape: drop the ESC but keep the word.
            err_d   = 1'b1;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_NORMAL;
          timer_d = '0;
        end
      endcase
    end else if (en_s && (state_q == ST_GOT_ESC)) begin
      if (timer_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = ST_NORMAL;
        timer_d = '0;
      end else begin
        timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
      end
    end else begin
      timer_d = timer_q;
    end

    if (valid_d) begin
      data_d = rx_if.in_rxdata;
    end else begin
      data_d = data_q;
    end

    if (flush_d) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end

    // An error in the same cycle as a clear wins: the count restarts at one.
    if (err_d) begin
      sticky_d  = 1'b1;
      err_cnt_d = (en_s && rx_if.in_clr_err) ? {{(CNT_W-1){1'b0}}, 1'b1}
                                              : sat_inc(err_cnt_q);
    end else if (en_s && rx_if.in_clr_err) begin
      sticky_d  = 1'b0;
      err_cnt_d = '0;
    end else begin
      sticky_d  = sticky_q;
      err_cnt_d = err_cnt_q;
    end

    if (vld_s) begin
      silence_d = '0;
    end else if (en_s && (silence_q != SIL_LIMIT)) begin
      silence_d = silence_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      silence_d = silence_q;
    end

    if (en_s) begin
      alive_d = (silence_d < SIL_LIMIT);
    end else begin
      alive_d = alive_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_NORMAL;
      timer_q     <= '0;
      silence_q   <= SIL_LIMIT;
      data_q      <= '0;
      valid_q     <= 1'b0;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      flush_cnt_q <= '0;
      err_cnt_q   <= '0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      silence_q   <= silence_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      flush_q     <= flush_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      flush_cnt_q <= flush_cnt_d;
      err_cnt_q   <= err_cnt_d;
      alive_q     <= alive_d;
    end
  end

  assign rx_if.out_rxdata       = data_q;
  assign rx_if.out_rxdata_valid = valid_q;
  assign rx_if.out_flush_seen   = flush_q;
  assign rx_if.out_esc_err      = err_q;
  assign rx_if.out_err_sticky   = sticky_q;
  assign rx_if.out_flush_cnt    = flush_cnt_q;
  assign rx_if.out_err_cnt      = err_cnt_q;
  assign rx_if.out_link_alive   = alive_q;

  rx_deflusher_chk u_chk (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush_seen   (flush_q),
    .rxdata_valid (valid_q)
  );
endmodule

// File: tb/tb_rx_deflusher.sv
// tb_rx_deflusher: directed scenarios plus randomized traffic for rx_deflusher,
// checked every cycle against a behavioural model of the escape protocol.
// A narrow counter width is used so counter saturation is reachable.
`ifndef ESC_PACK
`define ESC_PACK 192'hE5E5E5E5_E5E5E5E5_E5E5E5E5_E5E5E5E5_E5E5E5E5_E5E5E5E5
`endif
`ifndef FLUSH_PACK
`define FLUSH_PACK 192'hF1F1F1F1_F1F1F1F1_F1F1F1F1_F1F1F1F1_F1F1F1F1_F1F1F1F1
`endif

module tb_rx_deflusher;
  localparam int DW          = 192;
  localparam int CNT_W       = 4;
  localparam int ESC_TIMEOUT = 16;
  localparam int ALIVE_LIMIT = 32;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [DW-1:0] esc_w;
  logic [DW-1:0] flush_w;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit            m_pending;
  int            m_gap;
  int            m_silence;
  int            m_flush_cnt;
  int            m_err_cnt;
  bit            m_sticky;
  bit            m_valid;
  bit            m_fs;
  bit            m_ee;
  bit            m_alive;
  logic [DW-1:0] m_data;

  rx_deflusher_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  rx_deflusher #(
    .DW(DW), .ESC_TIMEOUT(ESC_TIMEOUT), .ALIVE_LIMIT(ALIVE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_if   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},   bus.out_rxdata, m_data);
    chk({tag, ".valid"},  DW'(bus.out_rxdata_valid), DW'(m_valid));
    chk({tag, ".flush"},  DW'(bus.out_flush_seen), DW'(m_fs));
    chk({tag, ".err"},    DW'(bus.out_esc_err), DW'(m_ee));
    chk({tag, ".sticky"}, DW'(bus.out_err_sticky), DW'(m_sticky));
    chk({tag, ".fcnt"},   DW'(bus.out_flush_cnt), DW'(m_flush_cnt));
    chk({tag, ".ecnt"},   DW'(bus.out_err_cnt), DW'(m_err_cnt));
    chk({tag, ".alive"},  DW'(bus.out_link_alive), DW'(m_alive));
  endtask

  task automatic model_reset();
    m_pending = 1'b0; m_gap = 0; m_silence = ALIVE_LIMIT;
    m_flush_cnt = 0; m_err_cnt = 0; m_sticky = 1'b0;
    m_valid = 1'b0; m_fs = 1'b0; m_ee = 1'b0; m_alive = 1'b0; m_data = '0;
  endtask

  // One clock of traffic: apply inputs, advance the model, check after the edge.
  task automatic step(input bit en, input bit v, input logic [DW-1:0] d, input bit clr,
                      input string tag);
    bit err;
    bus.in_enable = en; bus.in_rxdata_valid = v; bus.in_rxdata = d; bus.in_clr_err = clr;
    m_valid = 1'b0; m_fs = 1'b0; m_ee = 1'b0;
    if (en) begin
      err = 1'b0;
      if (v) begin
        m_silence = 0;
        if (!m_pending) begin
          if (d == esc_w) begin
            m_pending = 1'b1; m_gap = 0;
          end else begin
            m_valid = 1'b1; m_data = d;
          end
        end else begin
          m_pending = 1'b0;
          if (d == esc_w) begin
            m_valid = 1'b1; m_data = d;
          end else if (d == flush_w) begin
            m_fs = 1'b1;
            if (m_flush_cnt < CNT_MAX) m_flush_cnt++;
          end else begin
            err = 1'b1; m_valid = 1'b1; m_data = d;
          end
        end
      end else begin
        if (m_silence < ALIVE_LIMIT) m_silence++;
        if (m_pending) begin
          m_gap++;
          if (m_gap == ESC_TIMEOUT) begin
            err = 1'b1; m_pending = 1'b0;
          end
        end
      end
      if (err) begin
        m_ee = 1'b1; m_sticky = 1'b1;
        if (clr) m_err_cnt = 1;
        else if (m_err_cnt < CNT_MAX) m_err_cnt++;
      end else if (clr) begin
        m_sticky = 1'b0; m_err_cnt = 0;
      end
      m_alive = (m_silence < ALIVE_LIMIT);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [DW-1:0] wa, wb;

  initial begin
    esc_w   = `ESC_PACK;
    flush_w = `FLUSH_PACK;
    bus.in_enable = 1'b0; bus.in_rxdata_valid = 1'b0; bus.in_rxdata = '0; bus.in_clr_err = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0, "post_reset");

    // 1: plain words back to back
    step(1'b1, 1'b1, 192'hA, 1'b0, "t1_a");
    step(1'b1, 1'b1, 192'hB, 1'b0, "t1_b");
    step(1'b1, 1'b1, 192'hC, 1'b0, "t1_c");
    step(1'b1, 1'b0, '0, 1'b0, "t1_idle");

    // 2: ESC, three idle cycles, FLUSH
    step(1'b1, 1'b1, esc_w, 1'b0, "t2_esc");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, "t2_gap");
    step(1'b1, 1'b1, flush_w, 1'b0, "t2_flush");
    step(1'b1, 1'b0, '0, 1'b0, "t2_idle");

    // 3: escaped ESC followed by plain word
    step(1'b1, 1'b1, esc_w, 1'b0, "t3_esc");
    step(1'b1, 1'b1, esc_w, 1'b0, "t3_esc2");
    step(1'b1, 1'b1, 192'hD, 1'b0, "t3_d");

    // 4: malformed escape, then clear
    step(1'b1, 1'b1, esc_w, 1'b0, "t4_esc");
    step(1'b1, 1'b1, 192'hE, 1'b0, "t4_e");
    step(1'b1, 1'b0, '0, 1'b1, "t4_clr");

    // 5: escape timeout, then a plain word
    step(1'b1, 1'b1, esc_w, 1'b0, "t5_esc");
    for (int i = 0; i < ESC_TIMEOUT; i++) step(1'b1, 1'b0, '0, 1'b0, "t5_gap");
    step(1'b1, 1'b1, 192'hF, 1'b0, "t5_f");

    // 6: liveness drop after silence, enable freeze mid-escape
    for (int i = 0; i < ALIVE_LIMIT + 2; i++) step(1'b1, 1'b0, '0, 1'b0, "t6_silent");
    step(1'b1, 1'b1, 192'h11, 1'b0, "t6_word");
    step(1'b1, 1'b1, esc_w, 1'b0, "t6_esc");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, rand_word(), 1'b1, "t6_frozen");
    step(1'b1, 1'b1, flush_w, 1'b0, "t6_flush");

    // Counter saturation and clear colliding with an error
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      step(1'b1, 1'b1, esc_w, 1'b0, "sat_fesc");
      step(1'b1, 1'b1, flush_w, 1'b0, "sat_flush");
    end
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      step(1'b1, 1'b1, esc_w, 1'b0, "sat_eesc");
      step(1'b1, 1'b1, 192'h22, 1'b0, "sat_err");
    end
    step(1'b1, 1'b1, esc_w, 1'b0, "clrwin_esc");
    step(1'b1, 1'b1, 192'h33, 1'b1, "clrwin_err");

    // Reset while an escape is pending
    step(1'b1, 1'b1, esc_w, 1'b0, "rst_esc");
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all("rst_mid");
    reset_n = 1'b1;
    step(1'b1, 1'b1, 192'h44, 1'b0, "rst_after");

    // Randomized traffic with varying density
    for (int blk = 0; blk < 40; blk++) begin
      int pv;
      pv = (blk % 4 == 3) ? 8 : 70;
      for (int i = 0; i < 60; i++) begin
        int r;
        bit en, v, clr;
        en  = ($urandom_range(99) < 92);
        v   = ($urandom_range(99) < pv);
        clr = ($urandom_range(99) < 4);
        r   = $urandom_range(99);
        if (r < 30) wa = esc_w;
        else if (r < 45) wa = flush_w;
        else wa = rand_word();
        step(en, v, wa, clr, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
